vga_ordered_dither: RTL and testbench



---
 rtl/vga_ordered_dither.sv | 173 +++++++++++++++++
 tb/tb_vga_ordered_dither.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_ordered_dither.sv
// 4x4 Bayer ordered dither from 6-bit to 3-bit RGB, with syncs delayed to match the data.
// Define DITHER_TEMPORAL_EN to add a 2-bit frame counter that shifts the pattern every frame.

module vga_dither_lane #(
  parameter int VEC_W = 6,
  parameter int OUT_W = 3
) (
  input  logic [VEC_W-1:0] pix_i,
  input  logic [2:0]       t_i,
  output logic [OUT_W-1:0] pix_o
);
  logic [VEC_W:0] s;

  // A carry into the top bit means the sum passed full scale: clamp instead of wrapping.
  always_comb begin
    s     = {1'b0, pix_i} + {{(VEC_W-2){1'b0}}, t_i};
    pix_o = s[VEC_W] ? {OUT_W{1'b1}} : s[VEC_W-1 -: OUT_W];
  end
endmodule

module vga_ordered_dither #(
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic       CLK_50MHZ,
  input  logic       RST_n,
  input  logic       CE_PIX,
  input  logic       DITHER,
  input  logic [5:0] R_IN,
  input  logic [5:0] G_IN,
  input  logic [5:0] B_IN,
  input  logic       HS_IN,
  input  logic       VS_IN,
  output logic [2:0] VGA_R,
  output logic [2:0] VGA_G,
  output logic [2:0] VGA_B,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 6;
  localparam int OUT_W     = 3;

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] pix;
    logic [2:0]                      t;
    logic                            hs;
    logic                            vs;
  } s1_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][OUT_W-1:0] pix;
    logic                            hs;
    logic                            vs;
  } s2_t;

  localparam s1_t S1_RST = '{pix: '0, t: 3'd0, hs: ~HS_POL, vs: ~VS_POL};
  localparam s2_t S2_RST = '{pix: '0, hs: ~HS_POL, vs: ~VS_POL};

  logic       hs_d_q, hs_d_d;
  logic       vs_d_q, vs_d_d;
  logic [1:0] px_q, px_d;
  logic [1:0] ln_q, ln_d;
  logic       hs_edge, vs_edge;
  logic [1:0] row, col;
  logic [2:0] t_lkp;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic [NUM_LANES-1:0][VEC_W-1:0] pix_in;
  logic [NUM_LANES-1:0][OUT_W-1:0] dith;

  // Bayer entry already halved to the 0..7 threshold range.
  function automatic logic [2:0] bayer_t(input logic [1:0] r, input logic [1:0] c);
    logic [2:0] v;
    case ({r, c})
      4'h0: v = 3'd0;  4'h1: v = 3'd4;  4'h2: v = 3'd1;  4'h3: v = 3'd5;
      4'h4: v = 3'd6;  4'h5: v = 3'd2;  4'h6: v = 3'd7;  4'h7: v = 3'd3;
      4'h8: v = 3'd1;  4'h9: v = 3'd5;  4'hA: v = 3'd0;  4'hB: v = 3'd4;
      4'hC: v = 3'd7;  4'hD: v = 3'd3;  4'hE: v = 3'd6;  default: v = 3'd2;
    endcase
    return v;
  endfunction

  assign pix_in  = {R_IN, G_IN, B_IN};
  assign hs_edge = (HS_IN == HS_POL) && (hs_d_q != HS_POL);
  assign vs_edge = (VS_IN == VS_POL) && (vs_d_q != VS_POL);

`ifdef DITHER_TEMPORAL_EN
  logic [1:0] fr_q, fr_d;

  assign row = ln_q + {1'b0, fr_q[1]};
  assign col = px_q + {1'b0, fr_q[0]};

  always_comb begin
    fr_d = fr_q;
    if (CE_PIX && vs_edge) fr_d = fr_q + 2'd1;
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_n) begin
    if (!RST_n) fr_q <= 2'd0;
    else        fr_q <= fr_d;
  end
`else
  assign row = ln_q;
  assign col = px_q;
`endif

  assign t_lkp = bayer_t(row, col);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vga_dither_lane #(.VEC_W(VEC_W), .OUT_W(OUT_W)) u_lane (
      .pix_i (s1_q.pix[i]),
      .t_i   (s1_q.t),
      .pix_o (dith[i])
    );
  end

  always_comb begin
    hs_d_d = hs_d_q;
    vs_d_d = vs_d_q;
    px_d   = px_q;
    ln_d   = ln_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    if (CE_PIX) begin
      hs_d_d = HS_IN;
      vs_d_d = VS_IN;
      if (hs_edge) begin
        px_d = 2'd0;
        ln_d = ln_q + 2'd1;
      end else begin
        px_d = px_q + 2'd1;
      end
      // Frame start wins over the line increment in the same pixel.
      if (vs_edge) ln_d = 2'd0;

      s1_d.pix = pix_in;
      s1_d.t   = DITHER ? t_lkp : 3'd0;
      s1_d.hs  = HS_IN;
      s1_d.vs  = VS_IN;

      s2_d.pix = dith;
      s2_d.hs  = s1_q.hs;
      s2_d.vs  = s1_q.vs;
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_n) begin
    if (!RST_n) begin
      hs_d_q <= ~HS_POL;
      vs_d_q <= ~VS_POL;
      px_q   <= 2'd0;
      ln_q   <= 2'd0;
      s1_q   <= S1_RST;
      s2_q   <= S2_RST;
    end else begin
      hs_d_q <= hs_d_d;
      vs_d_q <= vs_d_d;
      px_q   <= px_d;
      ln_q   <= ln_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  assign VGA_R     = s2_q.pix[2];
  assign VGA_G     = s2_q.pix[1];
  assign VGA_B     = s2_q.pix[0];
  assign VGA_HSYNC = s2_q.hs;
  assign VGA_VSYNC = s2_q.vs;
endmodule

// File: tb/tb_vga_ordered_dither.sv
// Directed-vector bench for vga_ordered_dither (active-low syncs, expected values hand-computed).
module tb_vga_ordered_dither;
  logic       gclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       dither = 1'b0;
  logic [5:0] r = '0, g = '0, b = '0;
  logic       hs = 1'b1, vs = 1'b1;
  logic [2:0] vr, vg, vb;
  logic       vhs, vvs;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0] r, g, b;
    logic       hs, vs;
  } exp_t;

  localparam exp_t RST_EXP = '{r: 3'd0, g: 3'd0, b: 3'd0, hs: 1'b1, vs: 1'b1};

  exp_t pend = RST_EXP;
  exp_t last = RST_EXP;

  always #10 gclk = ~gclk;

  vga_ordered_dither #(.HS_POL(1'b0), .VS_POL(1'b0)) dut (
    .CLK_50MHZ (gclk),
    .RST_n     (rst_n),
    .CE_PIX    (ce),
    .DITHER    (dither),
    .R_IN      (r),
    .G_IN      (g),
    .B_IN      (b),
    .HS_IN     (hs),
    .VS_IN     (vs),
    .VGA_R     (vr),
    .VGA_G     (vg),
    .VGA_B     (vb),
    .VGA_HSYNC (vhs),
    .VGA_VSYNC (vvs)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".r"},  {29'd0, vr}, {29'd0, e.r});
    chk({tag, ".g"},  {29'd0, vg}, {29'd0, e.g});
    chk({tag, ".b"},  {29'd0, vb}, {29'd0, e.b});
    chk({tag, ".hs"}, {31'd0, vhs}, {31'd0, e.hs});
    chk({tag, ".vs"}, {31'd0, vvs}, {31'd0, e.vs});
  endtask

  // One pixel: optional CE-less cycle (outputs must hold), then one CE pulse.
  // After the pulse the outputs show the previous pixel's expected result.
  task automatic step(input string tag, input logic [5:0] ri, gi, bi, input logic hi, vi,
                      input logic [2:0] er, eg, eb, input bit gap);
    r = ri; g = gi; b = bi; hs = hi; vs = vi;
    if (gap) begin
      ce = 1'b0;
      @(posedge gclk); #1;
      chk_out({tag, ".hold"}, last);
    end
    ce = 1'b1;
    @(posedge gclk); #1;
    ce = 1'b0;
    chk_out(tag, pend);
    last = pend;
    pend = '{r: er, g: eg, b: eb, hs: hi, vs: vi};
  endtask

  task automatic reset_pipe();
    pend = RST_EXP;
    last = RST_EXP;
  endtask

  initial begin
    logic [2:0] e4[4];
    int lowcnt;

    #25;
    chk_out("rst", RST_EXP);
    @(negedge gclk) rst_n = 1'b1;
    reset_pipe();

    // Plain truncation
    dither = 1'b0;
    for (int i = 0; i < 4; i++) step("t1", 6'h2D, 6'h07, 6'h3F, 1, 1, 3'd5, 3'd0, 3'd7, 0);

`ifdef DITHER_TEMPORAL_EN
    // Frames 1..4 after reset see fr=1,2,3,0: t at (0,0) = 4,6,2,0; R=5 -> 1,1,0,0
    dither = 1'b1;
    e4 = '{3'd1, 3'd1, 3'd0, 3'd0};
    for (int f = 0; f < 4; f++) begin
      step("t6.edge", 6'h00, 6'h00, 6'h00, 0, 0, 3'd0, 3'd0, 3'd0, 0);
      step("t6.p0",   6'h05, 6'h00, 6'h00, 1, 1, e4[f], 3'd0, 3'd0, 0);
    end
`else
    // Pattern: line 0 t=0,4,1,5 and line 1 t=6,2,7,3 with R=7
    dither = 1'b1;
    step("t2.edge", 6'h00, 6'h00, 6'h00, 0, 0, 3'd0, 3'd0, 3'd0, 0);
    e4 = '{3'd0, 3'd1, 3'd1, 3'd1};
    for (int p = 0; p < 4; p++) step("t2.l0", 6'h07, 6'h00, 6'h00, 1, 1, e4[p], 3'd0, 3'd0, 0);
    step("t2.hs", 6'h00, 6'h00, 6'h00, 0, 1, 3'd0, 3'd0, 3'd0, 0);
    for (int p = 0; p < 4; p++) step("t2.l1", 6'h07, 6'h00, 6'h00, 1, 1, 3'd1, 3'd0, 3'd0, 0);

    // Saturation at px=2 ln=1 (t=7); G-only stays green at px=3
    step("t3.p0",  6'h00, 6'h00, 6'h00, 1, 1, 3'd0, 3'd0, 3'd0, 0);
    step("t3.p1",  6'h00, 6'h00, 6'h00, 1, 1, 3'd0, 3'd0, 3'd0, 0);
    step("t3.sat", 6'h3F, 6'h3F, 6'h3F, 1, 1, 3'd7, 3'd7, 3'd7, 0);
    step("t3.grn", 6'h00, 6'h3F, 6'h00, 1, 1, 3'd0, 3'd7, 3'd0, 0);
    // DITHER toggles per pixel: px0 ln1 off (R=7 -> 0), px1 ln1 on (t=2 -> 1)
    dither = 1'b0;
    step("t3.off", 6'h07, 6'h07, 6'h07, 1, 1, 3'd0, 3'd0, 3'd0, 0);
    dither = 1'b1;
    step("t3.on",  6'h07, 6'h07, 6'h07, 1, 1, 3'd1, 3'd1, 3'd1, 0);
`endif

    // 96-pixel HS pulse, CE every other clock
    dither = 1'b0;
    lowcnt = 0;
    for (int i = 0; i < 110; i++) begin
      logic [5:0] iv;
      iv = 6'(i);
      step("t4", iv, ~iv, 6'h00, (i < 4 || i >= 100) ? 1'b1 : 1'b0, 1, iv[5:3], ~iv[5:3], 3'd0, 1);
      if (vhs == 1'b0) lowcnt++;
    end
    chk("t4.hs_width", lowcnt, 96);

`ifndef DITHER_TEMPORAL_EN
    // Reset mid-frame
    dither = 1'b1;
    step("t5.vid", 6'h3F, 6'h3F, 6'h3F, 1, 1, 3'd7, 3'd7, 3'd7, 0);
    step("t5.vid", 6'h3F, 6'h3F, 6'h3F, 1, 1, 3'd7, 3'd7, 3'd7, 0);
    @(negedge gclk);
    hs = 1'b0; vs = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_out("t5.rst", RST_EXP);
    @(negedge gclk) rst_n = 1'b1;
    reset_pipe();
    // Syncs already active at release count as edges
    step("t5.edge", 6'h00, 6'h00, 6'h00, 0, 0, 3'd0, 3'd0, 3'd0, 0);
    step("t5.p0",   6'h07, 6'h07, 6'h07, 1, 1, 3'd0, 3'd0, 3'd0, 0);
    step("t5.p1",   6'h07, 6'h07, 6'h07, 1, 1, 3'd1, 3'd1, 3'd1, 0);
`endif

    step("flush", 6'h00, 6'h00, 6'h00, 1, 1, 3'd0, 3'd0, 3'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
